// File: rtl/bounce_pkg.sv
// Shared types for the sprite-motion scheduler and its update unit.
// Holds FSM state encodings, step width and divider width.
package bounce_pkg;

  localparam int STEP_W = 4;
  localparam int DIV_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // speed_sel 0..3 maps to step 1..4, zero-extended
  function automatic logic [STEP_W-1:0] step_of(
    input logic [1:0] sel
  );
    return STEP_W'(sel) + STEP_W'(1);
  endfunction

endpackage

// File: rtl/bounce_sched_if.sv
// Request channel from the scheduler to the position-update unit.
// Ports: upd_valid/upd_idx/upd_step (master out), upd_ready/upd_done (master in).
interface bounce_sched_if
  import bounce_pkg::*;
#(
  parameter int IW = 2
) ();

  logic              upd_valid;
  logic [IW-1:0]     upd_idx;
  logic [STEP_W-1:0] upd_step;
  logic              upd_ready;
  logic              upd_done;

  modport master (
    output upd_valid,
    output upd_idx,
    output upd_step,
    input  upd_ready,
    input  upd_done
  );

  modport slave (
    input  upd_valid,
    input  upd_idx,
    input  upd_step,
    output upd_ready,
    output upd_done
  );

endinterface

// File: rtl/bounce_sched_div.sv
// Frame divider: counts gated frame ticks, flags every FRAME_DIV-th one.
// Ports: clk, clr, frame_tick_i, run_i, pause_i in; eligible_o out (comb).
module frame_divider
  import bounce_pkg::*;
#(
  parameter int FRAME_DIV = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic frame_tick_i,
  input  logic run_i,
  input  logic pause_i,
  output logic eligible_o
);

  localparam logic [DIV_W-1:0] LAST =
    DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             count_en;

  assign count_en   = frame_tick_i & run_i & ~pause_i;
  assign eligible_o = count_en && (cnt_q == LAST);

  // pause freezes the count; run=0 clears it
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      !run_i:                  cnt_d = '0;
      eligible_o:              cnt_d = '0;
      count_en && !eligible_o: cnt_d = cnt_q + DIV_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bounce_sched.sv
// Frame-rate scheduler: one pass over sprites 0..NSPR-1 per FRAME_DIV ticks.
// Ports: clk, clr, frame_tick, run, pause, speed_sel in; sched_busy, overrun out; upd master.
module bounce_sched
  import bounce_pkg::*;
#(
  parameter int NSPR      = 4,
  parameter int FRAME_DIV = 2,
  parameter int IW        = (NSPR > 1) ? $clog2(NSPR) : 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          frame_tick,
  input  logic          run,
  input  logic          pause,
  input  logic [1:0]    speed_sel,
  output logic          sched_busy,
  output logic          overrun,
  bounce_sched_if.master upd
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NSPR - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic              eligible;
  logic              consume;

  frame_divider #(
    .FRAME_DIV (FRAME_DIV)
  ) u_div (
    .clk          (clk),
    .clr          (clr),
    .frame_tick_i (frame_tick),
    .run_i        (run),
    .pause_i      (pause),
    .eligible_o   (eligible)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    consume = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          consume = 1'b1;
          step_d  = step_of(speed_sel);
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (upd.upd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (upd.upd_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A tick landing on the consume edge re-arms pend
  // without counting as a drop.
  always_comb begin
    pend_d = pend_q & ~consume;
    ovr_d  = ovr_q;
    if (eligible) begin
      pend_d = 1'b1;
      if (pend_q && !consume) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      step_q  <= STEP_W'(1);
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign upd.upd_valid = (state_q == ST_ISSUE);
  assign upd.upd_idx   = idx_q;
  assign upd.upd_step  = step_q;
  assign sched_busy    = (state_q != ST_IDLE);
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_bounce_sched.sv
// Directed bench for bounce_sched (NSPR=4, FRAME_DIV=2).
// Inputs change at negedge; outputs are checked at negedge.
module tb_bounce_sched;

  logic       clk;
  logic       clr;
  logic       frame_tick;
  logic       run;
  logic       pause;
  logic [1:0] speed_sel;
  logic       sched_busy;
  logic       overrun;

  int vectors = 0;
  int miscmp  = 0;

  bounce_sched_if #(.IW(2)) u_if ();

  bounce_sched #(
    .NSPR      (4),
    .FRAME_DIV (2),
    .IW        (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .frame_tick (frame_tick),
    .run        (run),
    .pause      (pause),
    .speed_sel  (speed_sel),
    .sched_busy (sched_busy),
    .overrun    (overrun),
    .upd        (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic step(input logic t,
                      input logic r,
                      input logic d);
    frame_tick      = t;
    u_if.upd_ready  = r;
    u_if.upd_done   = d;
    @(negedge clk);
    frame_tick      = 1'b0;
    u_if.upd_ready  = 1'b0;
    u_if.upd_done   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  // expects divider at 0 and FSM idle
  task automatic start_pass();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("start_lat_v0", 32'(u_if.upd_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("start_v1", 32'(u_if.upd_valid), 32'd1);
  endtask

  task automatic xfer(input int i, input int s);
    chk("req_valid", 32'(u_if.upd_valid), 32'd1);
    chk("req_idx", 32'(u_if.upd_idx), 32'(i));
    chk("req_step", 32'(u_if.upd_step), 32'(s));
    step(1'b0, 1'b1, 1'b0);
    chk("wait_v0", 32'(u_if.upd_valid), 32'd0);
    chk("wait_busy", 32'(sched_busy), 32'd1);
  endtask

  // accept each request, done 3 cycles after accept
  task automatic pass_from(input int first, input int s);
    for (int i = first; i < 4; i++) begin
      xfer(i, s);
      idle(2);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("pass_end_busy", 32'(sched_busy), 32'd0);
    chk("pass_end_v", 32'(u_if.upd_valid), 32'd0);
  endtask

  initial begin
    clr            = 1'b1;
    frame_tick     = 1'b0;
    run            = 1'b1;
    pause          = 1'b0;
    speed_sel      = 2'b00;
    u_if.upd_ready = 1'b0;
    u_if.upd_done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(u_if.upd_valid), 32'd0);
    chk("rst_idx", 32'(u_if.upd_idx), 32'd0);
    chk("rst_step", 32'(u_if.upd_step), 32'd1);
    chk("rst_busy", 32'(sched_busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    clr = 1'b0;

    // basic pass
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    chk("tick1_idle", 32'(sched_busy), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("tick2_v0", 32'(u_if.upd_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("tick2_v1", 32'(u_if.upd_valid), 32'd1);
    pass_from(0, 1);
    idle(5);
    chk("no_extra_req", 32'(sched_busy), 32'd0);
    chk("basic_ovr", 32'(overrun), 32'd0);

    // step latched at pass start
    speed_sel = 2'b10;
    start_pass();
    speed_sel = 2'b00;
    pass_from(0, 3);
    start_pass();
    pass_from(0, 1);

    // ready held low in ISSUE
    start_pass();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("stall_v", 32'(u_if.upd_valid), 32'd1);
      chk("stall_idx", 32'(u_if.upd_idx), 32'd0);
    end
    pass_from(0, 1);

    // two eligible ticks during one pass
    start_pass();
    xfer(0, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("ovr_first_pend", 32'(overrun), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_held_idx", 32'(u_if.upd_idx), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    pass_from(1, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("pend_restart", 32'(u_if.upd_valid), 32'd1);
    pass_from(0, 1);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // pause at idx 1
    start_pass();
    xfer(0, 1);
    idle(2);
    step(1'b0, 1'b0, 1'b1);
    pause = 1'b1;
    pass_from(1, 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("pause_no_pass", 32'(sched_busy), 32'd0);
    end
    pause = 1'b0;
    start_pass();
    pass_from(0, 1);

    // clr in WAIT at idx 2, with a done on the same edge
    speed_sel = 2'b01;
    start_pass();
    for (int i = 0; i < 2; i++) begin
      xfer(i, 2);
      idle(2);
      step(1'b0, 1'b0, 1'b1);
    end
    xfer(2, 2);
    idle(1);
    clr = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    clr = 1'b0;
    chk("clr_valid", 32'(u_if.upd_valid), 32'd0);
    chk("clr_idx", 32'(u_if.upd_idx), 32'd0);
    chk("clr_step", 32'(u_if.upd_step), 32'd1);
    chk("clr_busy", 32'(sched_busy), 32'd0);
    chk("clr_ovr", 32'(overrun), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("late_done_busy", 32'(sched_busy), 32'd0);
    chk("late_done_idx", 32'(u_if.upd_idx), 32'd0);
    start_pass();
    pass_from(0, 2);

    // tick coinciding with the IDLE consume edge
    start_pass();
    xfer(0, 2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("mid_pend_ovr", 32'(overrun), 32'd0);
    xfer(1, 2);
    idle(2);
    step(1'b0, 1'b0, 1'b1);
    xfer(2, 2);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1);
    xfer(3, 2);
    idle(2);
    step(1'b0, 1'b0, 1'b1);
    chk("coinc_idle", 32'(sched_busy), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("coinc_v", 32'(u_if.upd_valid), 32'd1);
    chk("coinc_idx", 32'(u_if.upd_idx), 32'd0);
    chk("coinc_ovr", 32'(overrun), 32'd0);
    pass_from(0, 2);
    step(1'b0, 1'b0, 1'b0);
    chk("rearm_v", 32'(u_if.upd_valid), 32'd1);
    pass_from(0, 2);
    idle(4);
    chk("final_busy", 32'(sched_busy), 32'd0);
    chk("final_ovr", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscmp);
    $finish;
  end

endmodule
